// File: rtl/eth_tx_arbiter_if.sv
// Channel-side and GMII-side signal bundle for eth_tx_arbiter.
// master = frame builders / output stage, slave = the arbiter.
interface eth_tx_arbiter_if #(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 8
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH-1:0]        ch_done;
  logic [NUM_CH-1:0]        ch_tx_en;
  logic [NUM_CH*DATA_W-1:0] ch_txd;
  logic [NUM_CH-1:0]        ch_gnt;
  logic                     gmii_txd_valid;
  logic [DATA_W-1:0]        gmii_txd_data;
  logic                     busy;
  logic [CW-1:0]            active_ch;
  logic                     timeout_err;

  modport master (
    output ch_req, ch_done, ch_tx_en, ch_txd,
    input  ch_gnt, gmii_txd_valid, gmii_txd_data, busy, active_ch, timeout_err
  );

  modport slave (
    input  ch_req, ch_done, ch_tx_en, ch_txd,
    output ch_gnt, gmii_txd_valid, gmii_txd_data, busy, active_ch, timeout_err
  );
endinterface

// File: rtl/eth_tx_arbiter.sv
// GMII transmit arbiter: one grant at a time, registered data path, inter-frame gap, watchdog.
// Define ETH_TX_RR_EN for round-robin selection; otherwise fixed priority (channel 0 highest).
module eth_tx_arbiter #(
  parameter int NUM_CH     = 3,
  parameter int DATA_W     = 8,
  parameter int IFG_CYCLES = 12,
  parameter int MAX_CYC    = 2048
) (
  input  logic            i_clk,
  input  logic            i_resetn,
  eth_tx_arbiter_if.slave io_bus
);
  localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WD_W  = (MAX_CYC > 1) ? $clog2(MAX_CYC + 1) : 1;
  localparam int IFG_W = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;

  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(MAX_CYC - 1);
  localparam logic [IFG_W-1:0] GAP_LAST = (IFG_CYCLES > 0) ? IFG_W'(IFG_CYCLES - 1) : '0;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;
  // A zero-length gap skips GAP entirely so the next grant can follow two cycles after done.
  localparam logic [1:0] S_AFTER  = (IFG_CYCLES == 0) ? S_IDLE : S_GAP;

  logic [1:0]        r_state;
  logic [NUM_CH-1:0] r_gnt;
  logic [CW-1:0]     r_activeCh;
  logic [WD_W-1:0]   r_wdCnt;
  logic [IFG_W-1:0]  r_gapCnt;
  logic              r_txValid;
  logic [DATA_W-1:0] r_txData;
  logic              r_timeoutErr;
`ifdef ETH_TX_RR_EN
  logic [CW-1:0]     r_rrPtr;
`endif

  logic              w_anyReq;
  logic [CW-1:0]     w_winner;
  logic              w_selDone;
  logic              w_selEn;
  logic [DATA_W-1:0] w_selData;
  logic              w_expire;

  assign w_anyReq = |io_bus.ch_req;
  assign w_expire = (r_wdCnt == WD_LAST);

`ifdef ETH_TX_RR_EN
  // Scan outward from the pointer; the smallest rotated distance wins.
  always_comb begin
    w_winner = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      for (int j = 0; j < NUM_CH; j++) begin
        if (((int'(r_rrPtr) + k) == j) || ((int'(r_rrPtr) + k) == (j + NUM_CH))) begin
          if (io_bus.ch_req[j]) w_winner = CW'(j);
        end
      end
    end
  end
`else
  always_comb begin
    w_winner = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (io_bus.ch_req[k]) w_winner = CW'(k);
    end
  end
`endif

  always_comb begin
    w_selDone = 1'b0;
    w_selEn   = 1'b0;
    w_selData = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (r_activeCh == CW'(k)) begin
        w_selDone = io_bus.ch_done[k];
        w_selEn   = io_bus.ch_tx_en[k];
        w_selData = io_bus.ch_txd[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state      <= S_IDLE;
      r_gnt        <= '0;
      r_activeCh   <= '0;
      r_wdCnt      <= '0;
      r_gapCnt     <= '0;
      r_txValid    <= 1'b0;
      r_txData     <= '0;
      r_timeoutErr <= 1'b0;
`ifdef ETH_TX_RR_EN
      r_rrPtr      <= '0;
`endif
    end else begin
      r_timeoutErr <= 1'b0;
      r_txValid    <= 1'b0;
      r_txData     <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_anyReq) begin
            r_state    <= S_ACTIVE;
            r_gnt      <= NUM_CH'(1) << w_winner;
            r_activeCh <= w_winner;
            r_wdCnt    <= '0;
`ifdef ETH_TX_RR_EN
            r_rrPtr    <= (w_winner == CW'(NUM_CH - 1)) ? '0 : w_winner + 1'b1;
`endif
          end
        end
        S_ACTIVE: begin
          r_txValid <= w_selEn;
          r_txData  <= w_selData;
          r_wdCnt   <= r_wdCnt + 1'b1;
          // Done takes precedence over a simultaneous watchdog expiry.
          if (w_selDone || w_expire) begin
            r_gnt        <= '0;
            r_state      <= S_AFTER;
            r_gapCnt     <= '0;
            r_timeoutErr <= !w_selDone;
          end
        end
        S_GAP: begin
          if (r_gapCnt == GAP_LAST) r_state <= S_IDLE;
          else                      r_gapCnt <= r_gapCnt + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.ch_gnt         = r_gnt;
  assign io_bus.gmii_txd_valid = r_txValid;
  assign io_bus.gmii_txd_data  = r_txData;
  assign io_bus.busy           = (r_state != S_IDLE);
  assign io_bus.active_ch      = r_activeCh;
  assign io_bus.timeout_err    = r_timeoutErr;
endmodule

// File: doc/eth_tx_arbiter.md
# eth_tx_arbiter

Parametrised GMII transmit arbiter that multiplexes `NUM_CH` protocol transmitters (ARP, ICMP, UDP, future streams) onto one GMII transmit path. It grants exactly one requester at a time, forwards that channel's `tx_en`/`txd` through a one-cycle register stage, and enforces an inter-frame gap after every frame. A watchdog reclaims the bus from a channel that never signals done. It sits between the per-protocol frame builders and the GMII/RGMII output stage.

## Interface
- `NUM_CH`, 3: number of transmit channels (≥2); CW = max(1, clog2(NUM_CH)).
- `DATA_W`, 8: GMII data width.
- `IFG_CYCLES`, 12: forced idle cycles after each frame (0 allowed).
- `MAX_CYC`, 2048: watchdog limit in cycles per grant (≥2).
- `clk` in 1: clock.
- `resetn` in 1: reset; one clock; reset is asynchronous and active-low.
- `ch_req` in NUM_CH: per-channel level request, held until granted.
- `ch_done` in NUM_CH: per-channel frame-done pulse.
- `ch_tx_en` in NUM_CH: per-channel GMII valid.
- `ch_txd` in NUM_CH*DATA_W: per-channel data, channel i at [i*DATA_W +: DATA_W].
- `ch_gnt` out NUM_CH: one-hot grant, registered.
- `gmii_txd_valid` out 1: registered output valid.
- `gmii_txd_data` out DATA_W: registered output data.
- `busy` out 1: high in ACTIVE or GAP.
- `active_ch` out CW: index of current/last granted channel.
- `timeout_err` out 1: one-cycle pulse on watchdog expiry.

## Operation
- States: IDLE, ACTIVE, GAP. Reset state IDLE; reset values: `ch_gnt`=0, `gmii_txd_valid`=0, `gmii_txd_data`=0, `busy`=0, `active_ch`=0, `timeout_err`=0, RR pointer=0, counters=0.
- IDLE: if any `ch_req` bit set, select winner, register `ch_gnt` one-hot and `active_ch`, go ACTIVE; else stay.
- ACTIVE: output register loads `ch_tx_en[active_ch]`/`ch_txd[active_ch]` each cycle. Watchdog counter increments from 0.
  - `ch_done[active_ch]`=1 → clear `ch_gnt`, go GAP (or IDLE if IFG_CYCLES=0).
  - Counter reaches MAX_CYC-1 without done → clear `ch_gnt`, pulse `timeout_err`, go GAP/IDLE as above.
  - Done and watchdog expiry same cycle: done wins, no `timeout_err`.
- GAP: output register loads valid=0, data=0; counts IFG_CYCLES cycles then IDLE. Requests arriving in GAP wait.
- In IDLE and GAP output register holds valid=0, data=0.
- `ch_done` from non-granted channels ignored. `ch_tx_en` from non-granted channels never reaches output.
- Requests dropped by a channel before grant are simply not considered; grant once issued is not revoked by `ch_req` deassertion.
- Counters saturate-free: width clog2(MAX_CYC+1) and clog2(IFG_CYCLES+1), min 1.

## Timing
- Request visible in IDLE at cycle t → `ch_gnt`/`busy` high at t+1.
- Channel data at cycle t (while ACTIVE) → `gmii_txd_*` at t+1.
- Done at cycle t → `ch_gnt` low at t+1; data presented at t still forwarded at t+1; GAP occupies t+1..t+IFG_CYCLES; earliest next grant at t+IFG_CYCLES+2.
- `timeout_err` high for exactly the cycle after expiry, coincident with `ch_gnt` falling.
- Reset assertion mid-frame: all outputs zero immediately (asynchronous), no partial data after release.

## Configuration
- `ETH_TX_RR_EN` defined: round-robin; search starts at (last granted index + 1) mod NUM_CH, pointer updated on each grant.
- Undefined: fixed priority, lowest index wins (channel 0 = ARP reply highest); no pointer logic.

## Test plan
- Single request: `ch_req`=3'b010 at t → `ch_gnt`=3'b010 at t+1; 60 bytes 0x00..0x3B on ch1 appear on `gmii_txd_data` one cycle later; done → `busy` low after 12 gap cycles.
- Contention, all three requesting continuously: with `ETH_TX_RR_EN` grant order 0,1,2,0; without it 0,0,0.
- Watchdog: MAX_CYC=16, granted channel never pulses done → `ch_gnt` drops and `timeout_err` pulses exactly once, 16 cycles after grant.
- Isolation: ch2 drives `tx_en`=1, data 0xAA while ch0 granted idle → `gmii_txd_valid` stays 0; ch2 `ch_done` ignored, grant remains on ch0.
- IFG_CYCLES=0, back-to-back: done at t, other request pending → new grant at t+2, no valid output between frames.
- Reset mid-frame: `resetn` low during ACTIVE → all outputs 0 same cycle; after release, pending request granted from IDLE, RR pointer restarts at 0.
